// File: rtl/button_conditioner_if.sv
// Panel button bundle: raw active-low buttons in, conditioned commands and levels out.
interface button_conditioner_if;
  logic       add_n;
  logic       deduct_n;
  logic       switch_n;
  logic       add_pulse;
  logic       deduct_pulse;
  logic       mode;
  logic [2:0] pressed;

  modport master (
    output add_n, deduct_n, switch_n,
    input  add_pulse, deduct_pulse, mode, pressed
  );

  modport slave (
    input  add_n, deduct_n, switch_n,
    output add_pulse, deduct_pulse, mode, pressed
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises, debounces and auto-repeats the minute-counter panel buttons,
// producing one-cycle add/deduct commands and a toggling mode level.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input logic                 clk,
  input logic                 reset,
  button_conditioner_if.slave btn
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } repeatState_e;

  localparam logic [31:0] DbLimit = 32'(DEBOUNCE_CYCLES);
  localparam logic [31:0] RdLoad  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RpLoad  = 32'(REPEAT_PERIOD - 1);

  // Channel order everywhere: [0]=add, [1]=deduct, [2]=switch.
  logic [2:0]   rawAct;
  logic [2:0]   sync1_q, sync2_q;
  logic [2:0]   clean_q, clean_d;
  logic [31:0]  dbCnt_q [3];
  logic [31:0]  dbCnt_d [3];

  repeatState_e state_q [2];
  repeatState_e state_d [2];
  logic [31:0]  rptCnt_q [2];
  logic [31:0]  rptCnt_d [2];
  logic [1:0]   fire;

  logic addPulse_q, addPulse_d;
  logic deductPulse_q, deductPulse_d;
  logic mode_q, mode_d;

  assign rawAct = ~{btn.switch_n, btn.deduct_n, btn.add_n};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= rawAct;
      sync2_q <= sync1_q;
    end
  end

  // The counter runs only while the synchronised input disagrees with the clean level.
  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < 3; i++) begin
      dbCnt_d[i] = '0;
      if (sync2_q[i] != clean_q[i]) begin
        if (dbCnt_q[i] == DbLimit) begin
          clean_d[i] = ~clean_q[i];
        end else begin
          dbCnt_d[i] = dbCnt_q[i] + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clean_q <= '0;
      for (int i = 0; i < 3; i++) begin
        dbCnt_q[i] <= '0;
      end
    end else begin
      clean_q <= clean_d;
      for (int i = 0; i < 3; i++) begin
        dbCnt_q[i] <= dbCnt_d[i];
      end
    end
  end

  // Repeat FSMs look at the next clean level so the first pulse lands on the same edge as pressed.
  always_comb begin
    fire = '0;
    for (int i = 0; i < 2; i++) begin
      state_d[i]  = state_q[i];
      rptCnt_d[i] = rptCnt_q[i];
      if (!clean_d[i]) begin
        state_d[i]  = IDLE;
        rptCnt_d[i] = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            fire[i]     = 1'b1;
            state_d[i]  = DELAY;
            rptCnt_d[i] = RdLoad;
          end
          DELAY: begin
            if (rptCnt_q[i] == '0) begin
              fire[i]     = 1'b1;
              state_d[i]  = REPEAT;
              rptCnt_d[i] = RpLoad;
            end else begin
              rptCnt_d[i] = rptCnt_q[i] - 32'd1;
            end
          end
          REPEAT: begin
            if (rptCnt_q[i] == '0) begin
              fire[i]     = 1'b1;
              rptCnt_d[i] = RpLoad;
            end else begin
              rptCnt_d[i] = rptCnt_q[i] - 32'd1;
            end
          end
          default: begin
            state_d[i]  = IDLE;
            rptCnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]  <= IDLE;
        rptCnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i]  <= state_d[i];
        rptCnt_q[i] <= rptCnt_d[i];
      end
    end
  end

  // Simultaneous add/deduct cancel each other, and a held mode button masks both.
  always_comb begin
    addPulse_d    = fire[0] & ~fire[1] & ~clean_d[2];
    deductPulse_d = fire[1] & ~fire[0] & ~clean_d[2];
    mode_d        = mode_q ^ (clean_d[2] & ~clean_q[2]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addPulse_q    <= 1'b0;
      deductPulse_q <= 1'b0;
      mode_q        <= 1'b0;
    end else begin
      addPulse_q    <= addPulse_d;
      deductPulse_q <= deductPulse_d;
      mode_q        <= mode_d;
    end
  end

  assign btn.add_pulse    = addPulse_q;
  assign btn.deduct_pulse = deductPulse_q;
  assign btn.mode         = mode_q;
  assign btn.pressed      = clean_q;

endmodule
